// File: rtl/decode_stage.sv
// decode_stage: RV32/RV64 base (+optional M) instruction decoder with registered
// output and a skid entry, plus a saturating count of delivered illegal instructions.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_reg_we,
  output logic             out_alu_src,
  output logic             out_mem_we,
  output logic             out_pc_is_jmp,
  output logic             out_alu_not,
  output logic             out_illegal,
  output logic [1:0]       out_reg_sel_data_in,
  output logic [4:0]       out_alu_func,
  output logic [1:0]       out_mem_func_in,
  output logic [2:0]       out_mem_func_out,
  output logic [1:0]       out_pc_is_branch,
  output logic [CNT_W-1:0] illegal_count
);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b01000;
  localparam logic [4:0] ALU_SLT = 5'b00010, ALU_SLTU = 5'b00011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic            alu_src;
    logic            mem_we;
    logic            pc_is_jmp;
    logic            alu_not;
    logic            illegal;
    logic [1:0]      sel;
    logic [4:0]      alu_func;
    logic [1:0]      mem_in;
    logic [2:0]      mem_out;
    logic [1:0]      br;
  } pay_t;

  pay_t             w_dec, r_out, r_skid;
  logic [31:0]      w_imm;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic             w_m, w_ill, w_in_fire, w_out_fire;
  logic             r_out_valid, r_skid_valid, r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];
  assign w_m  = (ENABLE_M != 0) && (w_f7 == 7'b0000001);

  always_comb begin
    w_dec = '0;
    w_imm = '0;
    w_ill = 1'b0;
    w_dec.rs1 = in_instr[19:15];
    w_dec.rs2 = in_instr[24:20];
    w_dec.rd  = in_instr[11:7];
    case (in_instr[6:0])
      OP: begin
        w_ill = !(w_m || w_f7 == 7'b0000000 ||
                  (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
        w_dec.reg_we   = 1'b1;
        w_dec.alu_func = w_m ? {2'b10, w_f3} : {1'b0, in_instr[30], w_f3};
      end
      OP_IMM: begin
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_dec.reg_we   = 1'b1;
        w_dec.alu_src  = 1'b1;
        w_dec.alu_func = {1'b0, w_f3 == 3'b101 && in_instr[30], w_f3};
      end
      LOAD: begin
        w_ill = w_f3 == 3'b111 || (XLEN == 32 && (w_f3 == 3'b011 || w_f3 == 3'b110));
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_dec.reg_we  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.sel     = 2'b01;
        w_dec.mem_out = w_f3;
      end
      STORE: begin
        w_ill = w_f3 > 3'b010;
        w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_dec.mem_we  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.mem_in  = w_f3[1:0];
      end
      BRANCH: begin
        w_ill = w_f3[2:1] == 2'b01;
        w_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        w_dec.pc_is_jmp = 1'b1;
        w_dec.alu_func  = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        w_dec.alu_not   = ~(w_f3[2] ^ w_f3[0]);
      end
      JAL: begin
        w_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        w_dec.reg_we = 1'b1;
        w_dec.sel    = 2'b10;
        w_dec.br     = 2'b01;
      end
      JALR: begin
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_dec.reg_we  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.sel     = 2'b10;
        w_dec.br      = 2'b10;
      end
      LUI, AUIPC: begin
        w_imm = {in_instr[31:12], 12'b0};
        w_dec.reg_we  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.sel     = in_instr[5] ? 2'b00 : 2'b11;
      end
      default: w_ill = 1'b1;
    endcase
    w_dec.alu_func = w_ill ? ALU_ADD : w_dec.alu_func;
    w_dec.imm = XLEN'(signed'(w_imm));
    if (w_ill) begin
      w_dec = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.pc = in_pc;
  end

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // in_ready mirrors skid emptiness; a stalled output with a new input parks it in the skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_out_fire && r_out.illegal && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (!r_out_valid || out_ready) begin
        r_out_valid  <= r_skid_valid || w_in_fire;
        r_out        <= r_skid_valid ? r_skid : (w_in_fire ? w_dec : r_out);
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
  end

  assign in_ready            = r_in_ready;
  assign out_valid           = r_out_valid;
  assign out_pc              = r_out.pc;
  assign out_imm             = r_out.imm;
  assign out_rs1             = r_out.rs1;
  assign out_rs2             = r_out.rs2;
  assign out_rd              = r_out.rd;
  assign out_reg_we          = r_out.reg_we;
  assign out_alu_src         = r_out.alu_src;
  assign out_mem_we          = r_out.mem_we;
  assign out_pc_is_jmp       = r_out.pc_is_jmp;
  assign out_alu_not         = r_out.alu_not;
  assign out_illegal         = r_out.illegal;
  assign out_reg_sel_data_in = r_out.sel;
  assign out_alu_func        = r_out.alu_func;
  assign out_mem_func_in     = r_out.mem_in;
  assign out_mem_func_out    = r_out.mem_out;
  assign out_pc_is_branch    = r_out.br;
  assign illegal_count       = r_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus handshake, flush and reset sequences.
module tb_decode_stage;
  typedef struct packed {
    logic        il, we, src, mw, jmp, anot;
    logic [1:0]  sel;
    logic [4:0]  func;
    logic [1:0]  min;
    logic [2:0]  mout;
    logic [1:0]  br;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    logic        m_only;
    ctl_t        exp;
  } vec_t;

  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  int checks = 0, failures = 0;

  logic d_in_ready, d_out_valid, d_we, d_src, d_mw, d_jmp, d_not, d_il;
  logic [31:0] d_pc, d_imm;
  logic [4:0] d_rs1, d_rs2, d_rd, d_func;
  logic [1:0] d_sel, d_min, d_br, d_cnt;
  logic [2:0] d_mout;

  logic m_in_ready, m_out_valid, m_we, m_src, m_mw, m_jmp, m_not, m_il;
  logic [31:0] m_pc, m_imm;
  logic [4:0] m_rs1, m_rs2, m_rd, m_func;
  logic [1:0] m_sel, m_min, m_br, m_cnt;
  logic [2:0] m_mout;

  decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_pc(d_pc), .out_imm(d_imm), .out_rs1(d_rs1), .out_rs2(d_rs2), .out_rd(d_rd),
    .out_reg_we(d_we), .out_alu_src(d_src), .out_mem_we(d_mw), .out_pc_is_jmp(d_jmp),
    .out_alu_not(d_not), .out_illegal(d_il), .out_reg_sel_data_in(d_sel),
    .out_alu_func(d_func), .out_mem_func_in(d_min), .out_mem_func_out(d_mout),
    .out_pc_is_branch(d_br), .illegal_count(d_cnt)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(2)) u_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_pc), .out_imm(m_imm), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_rd(m_rd),
    .out_reg_we(m_we), .out_alu_src(m_src), .out_mem_we(m_mw), .out_pc_is_jmp(m_jmp),
    .out_alu_not(m_not), .out_illegal(m_il), .out_reg_sel_data_in(m_sel),
    .out_alu_func(m_func), .out_mem_func_in(m_min), .out_mem_func_out(m_mout),
    .out_pc_is_branch(m_br), .illegal_count(m_cnt)
  );

  ctl_t d_act, m_act, ill_c;
  assign d_act = {d_il, d_we, d_src, d_mw, d_jmp, d_not, d_sel, d_func, d_min, d_mout, d_br, d_imm, d_rs1, d_rs2, d_rd};
  assign m_act = {m_il, m_we, m_src, m_mw, m_jmp, m_not, m_sel, m_func, m_min, m_mout, m_br, m_imm, m_rs1, m_rs2, m_rd};

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  vec_t v[21];
  int cexp[5] = '{1, 2, 3, 3, 3};
  logic [31:0] s[4];
  logic [31:0] pc;
  int idx, got, acc;

  initial begin
    ill_c = '0;
    ill_c.il = 1'b1;
    v[0]  = '{32'hFFF10093, 0, '{0,1,1,0,0,0,2'b00,5'b00000,2'b00,3'b000,2'b00,32'hFFFFFFFF,5'd2,5'd31,5'd1}};
    v[1]  = '{32'h022081B3, 1, '{0,1,0,0,0,0,2'b00,5'b10000,2'b00,3'b000,2'b00,32'h0,5'd1,5'd2,5'd3}};
    v[2]  = '{32'hFE208EE3, 0, '{0,0,0,0,1,1,2'b00,5'b01000,2'b00,3'b000,2'b00,32'hFFFFFFFC,5'd1,5'd2,5'd29}};
    v[3]  = '{32'h00000000, 0, ill_c};
    v[4]  = '{32'h00832283, 0, '{0,1,1,0,0,0,2'b01,5'b00000,2'b00,3'b010,2'b00,32'h8,5'd6,5'd8,5'd5}};
    v[5]  = '{32'hFE742E23, 0, '{0,0,1,1,0,0,2'b00,5'b00000,2'b10,3'b000,2'b00,32'hFFFFFFFC,5'd8,5'd7,5'd28}};
    v[6]  = '{32'h403100B3, 0, '{0,1,0,0,0,0,2'b00,5'b01000,2'b00,3'b000,2'b00,32'h0,5'd2,5'd3,5'd1}};
    v[7]  = '{32'h4032D213, 0, '{0,1,1,0,0,0,2'b00,5'b01101,2'b00,3'b000,2'b00,32'h403,5'd5,5'd3,5'd4}};
    v[8]  = '{32'h12345537, 0, '{0,1,1,0,0,0,2'b00,5'b00000,2'b00,3'b000,2'b00,32'h12345000,5'd8,5'd3,5'd10}};
    v[9]  = '{32'hFFFFF097, 0, '{0,1,1,0,0,0,2'b11,5'b00000,2'b00,3'b000,2'b00,32'hFFFFF000,5'd31,5'd31,5'd1}};
    v[10] = '{32'hFF9FF0EF, 0, '{0,1,0,0,0,0,2'b10,5'b00000,2'b00,3'b000,2'b01,32'hFFFFFFF8,5'd31,5'd25,5'd1}};
    v[11] = '{32'h00008067, 0, '{0,1,1,0,0,0,2'b10,5'b00000,2'b00,3'b000,2'b10,32'h0,5'd1,5'd0,5'd0}};
    v[12] = '{32'h0020D063, 0, '{0,0,0,0,1,1,2'b00,5'b00010,2'b00,3'b000,2'b00,32'h0,5'd1,5'd2,5'd0}};
    v[13] = '{32'h0020E063, 0, '{0,0,0,0,1,0,2'b00,5'b00011,2'b00,3'b000,2'b00,32'h0,5'd1,5'd2,5'd0}};
    v[14] = '{32'h0020A063, 0, ill_c};
    v[15] = '{32'h00003003, 0, ill_c};
    v[16] = '{32'h00003023, 0, ill_c};
    v[17] = '{32'h40001033, 0, ill_c};
    v[18] = '{32'h00000011, 0, ill_c};
    v[19] = '{32'h0000007F, 0, ill_c};
    v[20] = '{32'h003140B3, 0, '{0,1,0,0,0,0,2'b00,5'b00100,2'b00,3'b000,2'b00,32'h0,5'd2,5'd3,5'd1}};
    for (int k = 0; k < 4; k++) s[k] = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;

    #1;
    chk("reset_state", {d_out_valid, d_in_ready, d_cnt, d_act, d_pc}, '0);
    repeat (2) @(negedge clk);
    chk("reset_held", {d_out_valid, d_in_ready, d_cnt}, '0);
    rst_n = 1;
    @(negedge clk);
    chk("in_ready_rise", d_in_ready, 1);

    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_instr = 0;
      @(negedge clk);
      chk($sformatf("zero_ill%0d", k), {d_out_valid, d_il, d_we, d_mw}, 4'b1100);
      in_valid = 0;
      @(negedge clk);
      chk($sformatf("ill_count%0d", k), d_cnt, cexp[k]);
    end

    for (int i = 0; i < 21; i++) begin
      pc = 32'h100 + 32'(i) * 4;
      in_valid = 1;
      in_instr = v[i].instr;
      in_pc = pc;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {d_out_valid, d_pc, d_act}, {1'b1, pc, v[i].exp});
      chk($sformatf("vec_m0_%0d", i), {m_out_valid, m_pc, m_act}, {1'b1, pc, v[i].m_only ? ill_c : v[i].exp});
    end
    in_valid = 0;
    @(negedge clk);

    idx = 0; got = 0; acc = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 3);
      in_valid = (idx < 4);
      if (idx < 4) in_instr = s[idx];
      #1;
      if (c == 2) chk("stall_in_ready", d_in_ready, 0);
      if (d_out_valid && out_ready) begin
        chk($sformatf("order%0d", got), d_rd, got + 1);
        got++;
      end
      if (in_valid && d_in_ready) begin
        idx++;
        if (c < 3) acc++;
      end
      @(negedge clk);
    end
    in_valid = 0;
    chk("stall_accepts", acc, 2);
    chk("delivered", {idx, got}, {32'd4, 32'd4});

    out_ready = 0;
    in_valid = 1;
    in_instr = s[0];
    @(negedge clk);
    in_instr = s[1];
    @(negedge clk);
    chk("full", {d_out_valid, d_in_ready}, 2'b10);
    flush = 1;
    in_instr = 32'h00900493;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush_full", {d_out_valid, d_in_ready}, 2'b01);
    flush = 1;
    in_valid = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush_drop", {d_out_valid, d_in_ready}, 2'b01);
    out_ready = 1;
    got = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_out_valid) got++;
    end
    chk("flush_no_ghost", got, 0);
    chk("flush_keeps_count", d_cnt, 3);

    out_ready = 0;
    in_valid = 1;
    in_instr = v[0].instr;
    @(negedge clk);
    in_valid = 0;
    chk("pre_reset_valid", d_out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset", {d_out_valid, d_in_ready, d_cnt, d_act, d_pc}, '0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("ready_low_after_release", d_in_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", {d_out_valid, d_in_ready}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
